// File: rtl/ieee1500_wsp_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ieee1500_pkg: shared FSM state encoding, WIR opcodes, length limit |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ieee1500_pkg;

    localparam int c_max_len = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [2:0] c_wir_bypass  = 3'b000;
    localparam logic [2:0] c_wir_extest  = 3'b001;
    localparam logic [2:0] c_wir_intest  = 3'b010;
    localparam logic [2:0] c_wir_sample  = 3'b011;
    localparam logic [2:0] c_wir_clamp   = 3'b100;
    localparam logic [2:0] c_wir_mbist   = 3'b101;
    localparam logic [2:0] c_wir_runbist = 3'b110;

endpackage
`default_nettype wire

// File: rtl/ieee1500_wsp_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ieee1500_wsp_controller_if: host request/response and WSP signals  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface ieee1500_wsp_controller_if
    import ieee1500_pkg::*;
#(
    parameter int MAX_LEN = c_max_len,
    parameter int LEN_W   = 6
) ();
    logic               start;
    logic               is_wir;
    logic [LEN_W-1:0]   length;
    logic [MAX_LEN-1:0] tx_data;
    logic               busy;
    logic               done;
    logic               err;
    logic [MAX_LEN-1:0] rx_data;
    logic               wsi;
    logic               wso;
    logic               selectwir, capturewir, shiftwir, updatewir;
    logic               selectwdr, capturewdr, shiftwdr, updatewdr;

    modport slave (
        input  start, is_wir, length, tx_data, wso,
        output busy, done, err, rx_data, wsi,
        output selectwir, capturewir, shiftwir, updatewir,
        output selectwdr, capturewdr, shiftwdr, updatewdr
    );

    modport master (
        output start, is_wir, length, tx_data, wso,
        input  busy, done, err, rx_data, wsi,
        input  selectwir, capturewir, shiftwir, updatewir,
        input  selectwdr, capturewdr, shiftwdr, updatewdr
    );
endinterface
`default_nettype wire

// File: rtl/ieee1500_wsp_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ieee1500_wsp_shifter: tx/rx shift registers and shift bit counter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ieee1500_wsp_shifter
    import ieee1500_pkg::*;
#(
    parameter int MAX_LEN = c_max_len,
    parameter int LEN_W   = 6
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               i_load,
    input  wire logic               i_shift,
    input  wire logic [LEN_W-1:0]   i_length,
    input  wire logic [MAX_LEN-1:0] i_tx_data,
    input  wire logic               i_wso,
    output logic                    o_wsi_bit,
    output logic                    o_cnt_zero,
    output logic [MAX_LEN-1:0]      o_rx_data
);
    logic [MAX_LEN-1:0] r_tx;
    logic [MAX_LEN-1:0] r_rx;
    logic [MAX_LEN-1:0] r_bit;
    logic [LEN_W-1:0]   r_cnt;

    // r_bit is a one-hot pointer to the rx bit written in the current shift cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx  <= '0;
            r_rx  <= '0;
            r_bit <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_tx  <= i_tx_data;
            r_rx  <= '0;
            r_bit <= MAX_LEN'(1);
            r_cnt <= i_length - LEN_W'(1);
        end else if (i_shift) begin
            r_tx  <= r_tx >> 1;
            r_rx  <= i_wso ? (r_rx | r_bit) : r_rx;
            r_bit <= r_bit << 1;
            if (!o_cnt_zero) begin
                r_cnt <= r_cnt - LEN_W'(1);
            end
        end
    end

    assign o_wsi_bit  = r_tx[0];
    assign o_cnt_zero = (r_cnt == '0);
    assign o_rx_data  = r_rx;

endmodule
`default_nettype wire

// File: rtl/ieee1500_wsp_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ieee1500_wsp_controller: sequences one WIR/WDR scan on the WSP     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ieee1500_wsp_controller
    import ieee1500_pkg::*;
#(
    parameter int MAX_LEN = c_max_len,
    parameter int LEN_W   = 6
) (
    input  wire logic               wrck,
    input  wire logic               wrstn,
    ieee1500_wsp_controller_if.slave bus
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_is_wir;
    logic               r_err;
    logic               w_len_ok;
    logic               w_accept;
    logic               w_reject;
    logic               w_sel, w_cap, w_shift, w_upd, w_done;
    logic               w_wsi_bit;
    logic               w_cnt_zero;
    logic [MAX_LEN-1:0] w_rx_data;

    assign w_len_ok = (bus.length != '0) && (int'(bus.length) <= MAX_LEN);
    assign w_accept = (r_state == ST_IDLE) && bus.start && w_len_ok;
    assign w_reject = (r_state == ST_IDLE) && bus.start && !w_len_ok;

    always_ff @(posedge wrck) begin
        if (!wrstn) begin
            r_state  <= ST_IDLE;
            r_is_wir <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_is_wir <= bus.is_wir;
            end
            if (r_state == ST_IDLE) begin
                r_err <= w_reject;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel       = 1'b0;
        w_cap       = 1'b0;
        w_shift     = 1'b0;
        w_upd       = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_len_ok ? ST_CAPTURE : ST_DONE;
                end
            end
            ST_CAPTURE: begin
                w_sel       = 1'b1;
                w_cap       = 1'b1;
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_sel   = 1'b1;
                w_shift = 1'b1;
                if (w_cnt_zero) begin
                    w_state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                w_sel       = 1'b1;
                w_upd       = 1'b1;
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    ieee1500_wsp_shifter #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shifter (
        .clk        (wrck),
        .rst_n      (wrstn),
        .i_load     (w_accept),
        .i_shift    (w_shift),
        .i_length   (bus.length),
        .i_tx_data  (bus.tx_data),
        .i_wso      (bus.wso),
        .o_wsi_bit  (w_wsi_bit),
        .o_cnt_zero (w_cnt_zero),
        .o_rx_data  (w_rx_data)
    );

    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = w_done;
    assign bus.err     = w_done && r_err;
    assign bus.rx_data = w_rx_data;
    assign bus.wsi     = w_shift && w_wsi_bit;

    // Only one of the two control groups is ever gated on by the latched scan type
    assign bus.selectwir  = w_sel   &&  r_is_wir;
    assign bus.capturewir = w_cap   &&  r_is_wir;
    assign bus.shiftwir   = w_shift &&  r_is_wir;
    assign bus.updatewir  = w_upd   &&  r_is_wir;
    assign bus.selectwdr  = w_sel   && !r_is_wir;
    assign bus.capturewdr = w_cap   && !r_is_wir;
    assign bus.shiftwdr   = w_shift && !r_is_wir;
    assign bus.updatewdr  = w_upd   && !r_is_wir;

endmodule
`default_nettype wire

// File: tb/tb_ieee1500_wsp_controller.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ieee1500_wsp_controller: controller paired with a 1500 wrapper  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ieee1500_wsp_controller;
    import ieee1500_pkg::*;

    typedef struct {
        logic        is_wir;
        logic [5:0]  len;
        logic [31:0] tx;
        logic [31:0] exp_rx;
        logic        exp_err;
        logic        chk_instr;
        logic [2:0]  exp_instr;
    } vec_t;

    typedef struct {
        logic [31:0] rx;
        logic        err;
        int          acc;
        int          lat;
        int          id;
    } sb_item_t;

    localparam int NV = 13;

    logic     wrck;
    logic     wrstn;
    int       cyc;
    int       n_cmp;
    int       n_bad;
    int       ctl_cnt;
    int       upd_cnt;
    int       cap_cnt;
    int       viol;
    vec_t     vecs [NV];
    sb_item_t sb_q [$];

    ieee1500_wsp_controller_if #(.MAX_LEN(32), .LEN_W(6)) bus ();

    ieee1500_wsp_controller #(.MAX_LEN(32), .LEN_W(6)) dut (
        .wrck  (wrck),
        .wrstn (wrstn),
        .bus   (bus)
    );

    // Wrapper model: 3-bit WIR, 1-bit bypass, 8-bit boundary register
    logic [2:0] wir_sr;
    logic [2:0] wir_instr;
    logic       byp;
    logic [7:0] bsr;
    logic [7:0] core_in;

    assign core_in = 8'hA5;
    assign bus.wso = bus.selectwir ? wir_sr[0] :
                     ((wir_instr == c_wir_bypass) ? byp : bsr[0]);

    always @(posedge wrck) begin
        if (!wrstn) begin
            wir_sr    <= 3'b000;
            wir_instr <= c_wir_bypass;
            byp       <= 1'b0;
            bsr       <= 8'h00;
        end else begin
            if (bus.capturewir)    wir_sr <= 3'b000;
            else if (bus.shiftwir) wir_sr <= {bus.wsi, wir_sr[2:1]};
            if (bus.updatewir)     wir_instr <= wir_sr;
            if (bus.capturewdr) begin
                if (wir_instr == c_wir_bypass) byp <= 1'b0;
                else                           bsr <= core_in;
            end else if (bus.shiftwdr) begin
                if (wir_instr == c_wir_bypass) byp <= bus.wsi;
                else                           bsr <= {bus.wsi, bsr[7:1]};
            end
        end
    end

    initial wrck = 1'b0;
    always #5 wrck = ~wrck;

    initial cyc = 0;
    always @(posedge wrck) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [63:0] outs();
        return {20'b0, bus.busy, bus.done, bus.err, bus.wsi,
                bus.selectwir, bus.capturewir, bus.shiftwir, bus.updatewir,
                bus.selectwdr, bus.capturewdr, bus.shiftwdr, bus.updatewdr,
                bus.rx_data};
    endfunction

    initial begin
        ctl_cnt = 0; upd_cnt = 0; cap_cnt = 0; viol = 0;
    end

    always @(negedge wrck) begin
        if (wrstn) begin
            if (bus.selectwir || bus.capturewir || bus.shiftwir || bus.updatewir ||
                bus.selectwdr || bus.capturewdr || bus.shiftwdr || bus.updatewdr)
                ctl_cnt <= ctl_cnt + 1;
            if (bus.updatewir || bus.updatewdr) upd_cnt <= upd_cnt + 1;
            if (bus.capturewir)                 cap_cnt <= cap_cnt + 1;
            if (((bus.selectwir || bus.capturewir || bus.shiftwir || bus.updatewir) &&
                 (bus.selectwdr || bus.capturewdr || bus.shiftwdr || bus.updatewdr)) ||
                (bus.wsi && !(bus.shiftwir || bus.shiftwdr)) ||
                ((!bus.busy || bus.done) && (bus.selectwir || bus.selectwdr)) ||
                ((bus.capturewir || bus.shiftwir || bus.updatewir) && !bus.selectwir) ||
                ((bus.capturewdr || bus.shiftwdr || bus.updatewdr) && !bus.selectwdr))
                viol <= viol + 1;
        end
    end

    // Scoreboard: every done pulse must match the oldest outstanding request
    always @(negedge wrck) begin : mon
        sb_item_t it;
        if (wrstn && bus.done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                it = sb_q.pop_front();
                check($sformatf("rx[%0d]", it.id), bus.rx_data, it.rx);
                check($sformatf("err[%0d]", it.id), bus.err, it.err);
                check($sformatf("latency[%0d]", it.id), cyc - it.acc + 1, it.lat);
            end
        end
    end

    task automatic run_op(input logic w, input logic [5:0] len, input logic [31:0] tx,
                          input logic [31:0] erx, input logic eerr,
                          input logic ci, input logic [2:0] ei, input int id);
        int       n;
        int       c0;
        sb_item_t it;
        n = 0;
        while (bus.busy && n < 50) begin @(negedge wrck); n++; end
        c0 = ctl_cnt;
        bus.is_wir  = w;
        bus.length  = len;
        bus.tx_data = tx;
        bus.start   = 1'b1;
        it.rx  = erx;
        it.err = eerr;
        it.acc = cyc + 1;
        it.lat = eerr ? 1 : int'(len) + 3;
        it.id  = id;
        sb_q.push_back(it);
        @(negedge wrck);
        bus.start = 1'b0;
        check($sformatf("busy_at_accept[%0d]", id), bus.busy, 1'b1);
        bus.is_wir  = ~w;
        bus.length  = 6'($urandom);
        bus.tx_data = $urandom;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin @(negedge wrck); n++; end
        if (sb_q.size() != 0) begin
            check($sformatf("done_timeout[%0d]", id), 64'd0, 64'd1);
            sb_q.delete();
        end
        #1;
        if (ci)   check($sformatf("wir_instr[%0d]", id), wir_instr, ei);
        if (eerr) check($sformatf("ctl_quiet[%0d]", id), ctl_cnt - c0, 0);
    endtask

    initial begin
        int n;
        int k;
        int u0;
        int c0;
        int base;
        sb_item_t it;

        n_cmp = 0; n_bad = 0;
        wrstn = 1'b0;
        bus.start = 1'b0; bus.is_wir = 1'b0; bus.length = '0; bus.tx_data = '0;

        //          is_wir len    tx             exp_rx         err   chk   instr
        vecs[0]  = '{1'b1, 6'd3,  32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 1'b1, c_wir_extest};
        vecs[1]  = '{1'b1, 6'd3,  32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, c_wir_bypass};
        vecs[2]  = '{1'b0, 6'd2,  32'h0000_0003, 32'h0000_0002, 1'b0, 1'b1, c_wir_bypass};
        vecs[3]  = '{1'b1, 6'd3,  32'h0000_0003, 32'h0000_0000, 1'b0, 1'b1, c_wir_sample};
        vecs[4]  = '{1'b0, 6'd16, 32'h0000_3C5A, 32'h0000_5AA5, 1'b0, 1'b0, 3'b000};
        vecs[5]  = '{1'b0, 6'd32, 32'h1234_5678, 32'h3456_78A5, 1'b0, 1'b0, 3'b000};
        vecs[6]  = '{1'b0, 6'd1,  32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 3'b000};
        vecs[7]  = '{1'b0, 6'd0,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, c_wir_sample};
        vecs[8]  = '{1'b1, 6'd33, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, c_wir_sample};
        vecs[9]  = '{1'b0, 6'd63, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, c_wir_sample};
        vecs[10] = '{1'b1, 6'd5,  32'h0000_0006, 32'h0000_0010, 1'b0, 1'b1, c_wir_extest};
        vecs[11] = '{1'b0, 6'd8,  32'h0000_00FF, 32'h0000_00A5, 1'b0, 1'b1, c_wir_extest};
        vecs[12] = '{1'b1, 6'd3,  32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1, c_wir_clamp};

        repeat (3) @(posedge wrck);
        @(negedge wrck);
        check("reset_outputs", outs(), 64'd0);

        // Release and request on the same cycle: first edge after reset must accept
        wrstn = 1'b1;
        for (int i = 0; i < NV; i++)
            run_op(vecs[i].is_wir, vecs[i].len, vecs[i].tx, vecs[i].exp_rx,
                   vecs[i].exp_err, vecs[i].chk_instr, vecs[i].exp_instr, i);

        // Reset during shift cycle 5 of a 16-bit data scan
        n = 0;
        while (bus.busy && n < 50) begin @(negedge wrck); n++; end
        u0 = upd_cnt;
        bus.is_wir = 1'b0; bus.length = 6'd16; bus.tx_data = 32'h0000_BEEF; bus.start = 1'b1;
        @(negedge wrck);
        bus.start = 1'b0;
        k = 0; n = 0;
        while (n < 40) begin
            @(negedge wrck);
            n++;
            if (bus.shiftwdr) k++;
            if (k == 6) break;
        end
        check("shift5_reached", k, 6);
        wrstn = 1'b0;
        @(negedge wrck);
        check("abort_outputs", outs(), 64'd0);
        @(negedge wrck);
        #1;
        check("abort_no_update", upd_cnt - u0, 0);
        wrstn = 1'b1;
        run_op(1'b1, 6'd3, 32'h0000_0001, 32'h0, 1'b0, 1'b1, c_wir_extest, 20);

        // start held high: back-to-back operations, one IDLE cycle between them
        n = 0;
        while (bus.busy && n < 50) begin @(negedge wrck); n++; end
        c0 = cap_cnt;
        base = cyc + 1;
        bus.is_wir = 1'b1; bus.length = 6'd3; bus.tx_data = 32'h0000_0001; bus.start = 1'b1;
        for (int j = 0; j < 3; j++) begin
            it.rx = 32'h0; it.err = 1'b0; it.acc = base + 7 * j; it.lat = 6; it.id = 30 + j;
            sb_q.push_back(it);
        end
        n = 0;
        while (cyc < base + 14 && n < 60) begin @(negedge wrck); n++; end
        bus.start = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin @(negedge wrck); n++; end
        if (sb_q.size() != 0) begin
            check("held_start_timeout", 64'd0, 64'd1);
            sb_q.delete();
        end
        repeat (10) @(negedge wrck);
        #1;
        check("held_start_captures", cap_cnt - c0, 3);
        check("held_start_instr", wir_instr, c_wir_extest);
        check("invariants", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ieee1500_wsp_controller.md
IEEE1500_WSP_CONTROLLER -- requirements
Module: ieee1500_wsp_controller

Interface
REQ-001 Parameter MAX_LEN, default 32: maximum scan length in bits; max 32.
REQ-002 Parameter LEN_W, default 6: width of the length input.
REQ-003 wrck  input  1  wrapper clock; the only clock; all logic on its rising edge.
REQ-004 wrstn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request a scan operation; sampled only in IDLE.
REQ-006 is_wir  input  1  1 = instruction-register scan; 0 = data-register scan.
REQ-007 length  input  LEN_W  number of shift cycles (1..MAX_LEN).
REQ-008 tx_data  input  MAX_LEN  bits to shift in, LSB first.
REQ-009 busy  output  1  high from the accepting edge until the end of DONE.
REQ-010 done  output  1  one-cycle pulse at operation end.
REQ-011 err  output  1  one-cycle pulse, coincident with done, on an illegal length.
REQ-012 rx_data  output  MAX_LEN  captured wso bits, LSB first; held until the next accepted start.
REQ-013 wsi  output  1  wrapper serial input drive.
REQ-014 wso  input  1  wrapper serial output, combinational from the wrapper.
REQ-015 selectwir, capturewir, shiftwir, updatewir  output  1 each  WIR controls.
REQ-016 selectwdr, capturewdr, shiftwdr, updatewdr  output  1 each  WDR controls.

Function
REQ-017 FSM states SHALL be IDLE, CAPTURE, SHIFT, UPDATE and DONE, with one-hot WSP control decode from the state.
REQ-018 IDLE -> CAPTURE SHALL occur when start=1 and 1<=length<=MAX_LEN; is_wir, length and tx_data are latched on that edge.
REQ-019 IDLE -> DONE SHALL occur when start=1 and length is 0 or greater than MAX_LEN; err and done pulse, no select/capture/shift/update is asserted, and rx_data is unchanged.
REQ-020 CAPTURE SHALL last exactly 1 cycle: select plus capture of the latched register asserted.
REQ-021 SHIFT SHALL last exactly length cycles: select plus shift asserted, with a down-counter loaded with length-1 that exits at 0.
REQ-022 In shift cycle i (0-based), wsi SHALL equal tx_data[i], and rx_data[i] SHALL take the value of wso sampled at the end of that cycle.
REQ-023 rx_data bits at or above length SHALL be cleared to 0 at acceptance.
REQ-024 UPDATE SHALL last exactly 1 cycle: select plus update asserted; then DONE.
REQ-025 DONE SHALL last exactly 1 cycle with done=1, then IDLE.
REQ-026 Latency for a legal request accepted at edge N: CAPTURE in cycle N+1, SHIFT in cycles N+2..N+1+L, UPDATE in cycle N+2+L, done in cycle N+3+L.
REQ-027 WIR and WDR control groups SHALL never be asserted simultaneously.
REQ-028 Select SHALL be continuous from CAPTURE through UPDATE.
REQ-029 Outside SHIFT, wsi SHALL be 0.
REQ-030 In IDLE and DONE, all eight WSP controls SHALL be 0.
REQ-031 start while busy SHALL be ignored; no queuing.
REQ-032 Changes to is_wir, length or tx_data after acceptance SHALL have no effect.

Reset
REQ-033 While wrstn=0 at a rising edge: state=IDLE, busy=0, done=0, err=0, rx_data=0, wsi=0, all WSP controls=0, counter=0.
REQ-034 Reset mid-operation SHALL abort without an UPDATE pulse; outputs follow REQ-033 from the next edge.
REQ-035 The first start SHALL be accepted on the first edge after wrstn returns high.

Structure
REQ-036 Shared package ieee1500_pkg SHALL hold the FSM state encoding, the WIR opcodes (BYPASS=000, EXTEST=001, INTEST=010, SAMPLE=011, CLAMP=100, MBIST=101, RUNBIST=110) and the MAX_LEN default.
REQ-037 One sub-module, ieee1500_wsp_shifter, SHALL hold the tx/rx shift registers and the bit counter; the FSM and control decode stay in the top level.

Verification (bench pairs the controller with the 1500 wrapper)
REQ-038 After reset: WIR scan, length=3, tx=3'b001 -> rx=3'b000; done 6 cycles after acceptance; wrapper instruction becomes EXTEST.
REQ-039 Wrapper instruction BYPASS: WDR scan, length=2, tx=2'b11 -> rx[0]=0 (bypass reset value), rx[1]=1.
REQ-040 Wrapper instruction SAMPLE with core_inputs=8'hA5: WDR scan of length 16 -> done at cycle 19; wso bits match the wrapper's captured shift register in LSB-first order.
REQ-041 length=0, then length=33 -> each gives done=err=1 on the cycle after acceptance, no WSP control toggles, rx_data unchanged.
REQ-042 wrstn low during shift cycle 5 of a 16-bit scan -> no update pulse, all outputs 0; a next WIR scan completes normally.
REQ-043 start held high through a whole operation -> exactly back-to-back operations with one IDLE cycle between DONE and the next CAPTURE; no start is accepted while busy.
